ps2_key_rx: RTL and testbench
=============================

Name: ps2_key_rx

Overview:
- PS/2 keyboard receiver. It samples the raw ps2clk/ps2data pins (usb_fpga_dp/dn with pull-ups) and produces one-cycle key events for the galaksija keyboard matrix logic.
- Handles synchronisation, glitch filtering, 11-bit framing, odd parity, a bit-gap timeout, and the E0/F0 prefix bytes.
- Runs in the pixel clock domain (25 MHz) directly upstream of the keyboard matrix.

Parameters:
- C_clk_freq_hz, 25000000, frequency of clk in Hz.
- C_filter_len, 8, number of consecutive equal synchronised samples needed before a filtered line changes state.
- C_timeout_us, 2000, maximum allowed gap between falling edges inside a frame. Timeout cycles = C_clk_freq_hz/1000000*C_timeout_us (50000 at default).

Ports:
- clk  input  1  system clock (clk_pixel)
- reset  input  1  synchronous, active-high reset
- ps2clk  input  1  raw PS/2 clock pin, asynchronous
- ps2data  input  1  raw PS/2 data pin, asynchronous
- key_valid  output  1  one-cycle pulse, key event is valid
- key_code  output  8  scan code of the event (set 2)
- key_ext  output  1  event was preceded by E0
- key_release  output  1  event was preceded by F0 (break)
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error
- busy  output  1  high while a frame is being received (FSM not IDLE)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: key_valid=0, key_code=0x00, key_ext=0, key_release=0, frame_err=0, busy=0. Filtered clock and data = 1, FSM = IDLE, prefix flags cleared, timeout counter = 0.
- Synchroniser: 2-FF on each pin, then the glitch filter.
- Glitch filter: per-line counter. The filtered value takes the synchronised value only after C_filter_len consecutive equal samples that differ from the current filtered value. Shorter pulses are ignored.
- Edge detection: a falling edge is filtered clock 1->0, registered, and produces a one-cycle fall strobe. Data is sampled from filtered data in the fall-strobe cycle.
- FSM, one transition per fall strobe:
  - IDLE: data=0 -> DATA with bit index 0. data=1 -> stay in IDLE; spurious edge, no error.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: -> IDLE. Frame is good iff stop=1 and XOR(8 data bits, parity)=1 (odd parity). Bad frame -> frame_err pulse, byte discarded, prefix flags cleared.
- Timeout: counter clears on every fall strobe and increments while FSM != IDLE, saturating. Reaching the timeout value -> FSM=IDLE, frame_err pulse, prefix flags cleared. Counter is held at 0 in IDLE.
- Byte decode on a good frame, in the cycle after the stop strobe:
  - 0xE0: set ext flag, no event.
  - 0xF0: set release flag, no event.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF (BAT, ack, resend, echo, overrun): no event, flags cleared.
  - 0xE1: treated as an ordinary code (Pause is not decoded specially).
  - Any other byte: key_valid=1 for exactly one cycle, key_code=byte, key_ext=ext flag, key_release=release flag. Flags clear in the same cycle.
- Output hold: key_code, key_ext and key_release hold their values until the next event.
- Latency: key_valid is asserted exactly 2 clk cycles after the clk edge on which the stop-bit fall strobe is high. frame_err uses the same latency for parity/stop errors, and 1 cycle after the timeout count is reached.
- key_valid and frame_err are never high in the same cycle.
- Prefix chain: E0 then F0 in either order are both latched. A repeated prefix is idempotent.
- busy = (FSM != IDLE), registered.
- Reset mid-frame: everything returns to reset values and the partial frame is discarded. If reset releases mid-frame, the remaining edges resync via the start-bit check, the parity/stop checks and the timeout. No spurious key_valid unless those bits happen to form a legal frame.
- Simultaneous events: reset has priority over the fall strobe and the timeout. A fall strobe in the same cycle as the timeout terminal count is processed as an edge (counter clears) and no timeout fires.

Test Plan:
- Frame 0x1C with parity=0, stop=1, bit period 80 us -> single key_valid, key_code=0x1C, key_ext=0, key_release=0, frame_err stays 0.
- Bytes F0,1C -> one event: key_code=0x1C, key_release=1, key_ext=0. Then E0,F0,75 -> one event: key_code=0x75, key_ext=1, key_release=1. Flags are 0 on a following plain 0x1C.
- Frame 0x1C sent with parity=1 -> frame_err pulse, no key_valid. The next good 0x29 -> key_code=0x29, key_release=0 (flags were cleared).
- ps2clk stops after 5 bits -> frame_err exactly 50001 cycles after the last fall strobe, busy drops. The next good 0x1C decodes correctly.
- 3-cycle low glitch on ps2clk while idle, and a 7-cycle glitch mid-frame -> no state change. Frame 0x1C still decodes.
- reset asserted for 1 cycle after the 4th data bit -> all outputs 0 immediately after. The following full 0x5A frame -> key_code=0x5A.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: pin synchronisation, glitch filtering, 11-bit framing
// with odd parity and bit-gap timeout, and E0/F0 prefix decoding into key events.

module ps2_key_rx_filter #(
    parameter int unsigned C_filter_len = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic filt_o
);
    localparam int unsigned C_CNT_W = $clog2(C_filter_len + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_filter_len - 1);

    logic               meta_q;
    logic               sync_q;
    logic               filt_q, filt_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    // The filtered level only moves after a full run of differing samples;
    // any sample equal to the current level restarts the run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == C_CNT_LAST) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

module ps2_key_rx #(
    parameter int unsigned C_clk_freq_hz = 25000000,
    parameter int unsigned C_filter_len  = 8,
    parameter int unsigned C_timeout_us  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned C_TO_CYCLES = C_clk_freq_hz / 1000000 * C_timeout_us;
    localparam int unsigned C_TO_W = $clog2(C_TO_CYCLES + 1);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(C_TO_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic              clk_filt;
    logic              data_filt;
    logic              clk_prev_q;
    logic              fall_q;

    state_t            state_q, state_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [C_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic              timeout_fire;

    logic              rx_done_q, rx_done_d;
    logic              rx_ok_q, rx_ok_d;

    logic              ext_q, ext_d;
    logic              rel_q, rel_d;
    logic              evt_valid_q, evt_valid_d;
    logic              evt_err_q, evt_err_d;
    logic [7:0]        evt_code_q, evt_code_d;
    logic              evt_ext_q, evt_ext_d;
    logic              evt_rel_q, evt_rel_d;

    logic              key_valid_q, key_valid_d;
    logic [7:0]        key_code_q, key_code_d;
    logic              key_ext_q, key_ext_d;
    logic              key_rel_q, key_rel_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    ps2_key_rx_filter #(
        .C_filter_len(C_filter_len)
    ) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .pin_i (ps2clk),
        .filt_o(clk_filt)
    );

    ps2_key_rx_filter #(
        .C_filter_len(C_filter_len)
    ) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .pin_i (ps2data),
        .filt_o(data_filt)
    );

    // An edge arriving on the terminal count wins over the timeout.
    assign timeout_fire = (state_q != S_IDLE) && !fall_q && (to_cnt_q == C_TO_LAST);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_done_d = 1'b0;
        rx_ok_d   = 1'b0;
        to_cnt_d  = to_cnt_q;

        if (fall_q || state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != C_TO_LAST) begin
            to_cnt_d = to_cnt_q + C_TO_W'(1);
        end

        if (timeout_fire) begin
            state_d  = S_IDLE;
            to_cnt_d = '0;
        end else if (fall_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_filt) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_filt, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = data_filt;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d   = S_IDLE;
                    rx_done_d = 1'b1;
                    rx_ok_d   = data_filt & ((^shift_q) ^ par_q);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ext_d       = ext_q;
        rel_d       = rel_q;
        evt_valid_d = 1'b0;
        evt_err_d   = 1'b0;
        evt_code_d  = evt_code_q;
        evt_ext_d   = evt_ext_q;
        evt_rel_d   = evt_rel_q;

        if (rx_done_q) begin
            if (!rx_ok_q) begin
                evt_err_d = 1'b1;
                ext_d     = 1'b0;
                rel_d     = 1'b0;
            end else begin
                case (shift_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: rel_d = 1'b1;
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                    default: begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = shift_q;
                        evt_ext_d   = ext_q;
                        evt_rel_d   = rel_q;
                        ext_d       = 1'b0;
                        rel_d       = 1'b0;
                    end
                endcase
            end
        end

        if (timeout_fire) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end

    always_comb begin
        key_valid_d = evt_valid_q;
        key_code_d  = evt_valid_q ? evt_code_q : key_code_q;
        key_ext_d   = evt_valid_q ? evt_ext_q  : key_ext_q;
        key_rel_d   = evt_valid_q ? evt_rel_q  : key_rel_q;
        frame_err_d = evt_err_q | timeout_fire;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            rx_done_q   <= 1'b0;
            rx_ok_q     <= 1'b0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_err_q   <= 1'b0;
            evt_code_q  <= '0;
            evt_ext_q   <= 1'b0;
            evt_rel_q   <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_prev_q  <= clk_filt;
            fall_q      <= clk_prev_q & ~clk_filt;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            rx_done_q   <= rx_done_d;
            rx_ok_q     <= rx_ok_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            evt_valid_q <= evt_valid_d;
            evt_err_q   <= evt_err_d;
            evt_code_q  <= evt_code_d;
            evt_ext_q   <= evt_ext_d;
            evt_rel_q   <= evt_rel_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_rel_q   <= key_rel_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_rel_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed and random PS/2 frames driven on the pins,
// outputs compared every cycle against a frame-level model of the receiver.

module tb_ps2_key_rx;
    localparam int unsigned FREQ  = 25000000;
    localparam int unsigned FILT  = 8;
    localparam int unsigned TO_US = 20;
    localparam longint      T     = longint'(FREQ / 1000000 * TO_US);
    // posedges from the first pin-low sample to the edge that consumes the strobe
    localparam longint      LAT   = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    ps2_key_rx #(
        .C_clk_freq_hz(FREQ),
        .C_filter_len (FILT),
        .C_timeout_us (TO_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;

    logic [7:0] specials [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    longint q_s [$];
    bit     q_d [$];
    bit     m_in_frame;
    int     m_nb;
    bit     m_bits [10];
    longint m_last_s;
    bit     m_ext, m_rel;
    longint p_at;
    bit     p_err;
    logic [7:0] p_code;
    bit     p_ext, p_rel;
    logic   e_kv, e_err, e_busy, e_ext, e_rel;
    logic [7:0] e_code;
    bit     started = 1'b0;

    int     kv_cnt = 0;
    int     err_cnt = 0;
    longint last_err_cyc = 0;
    longint last_edge_s = 0;

    function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    function void model_reset();
        q_s.delete();
        q_d.delete();
        m_in_frame = 1'b0;
        m_nb = 0;
        m_ext = 1'b0;
        m_rel = 1'b0;
        p_at = -1;
        e_kv = 1'b0;
        e_err = 1'b0;
        e_busy = 1'b0;
        e_code = 8'h00;
        e_ext = 1'b0;
        e_rel = 1'b0;
    endfunction

    function void finish_frame(input longint n);
        int ones;
        bit ok;
        bit special;
        logic [7:0] b;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            b[i] = m_bits[i];
            ones += int'(m_bits[i]);
        end
        ok = (m_bits[9] == 1'b1) && (((ones + int'(m_bits[8])) % 2) == 1);
        special = 1'b0;
        foreach (specials[i]) if (specials[i] == b) special = 1'b1;
        if (!ok) begin
            p_at = n + 2; p_err = 1'b1;
            m_ext = 1'b0; m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (special) begin
            m_ext = 1'b0; m_rel = 1'b0;
        end else begin
            p_at = n + 2; p_err = 1'b0;
            p_code = b; p_ext = m_ext; p_rel = m_rel;
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endfunction

    function void model_step(input longint n);
        bit has_edge;
        bit d;
        e_kv = 1'b0;
        e_err = 1'b0;
        while (q_s.size() > 0 && q_s[0] < n) begin
            void'(q_s.pop_front());
            void'(q_d.pop_front());
        end
        has_edge = (q_s.size() > 0) && (q_s[0] == n);
        if (m_in_frame && !has_edge && n == m_last_s + T + 1) begin
            m_in_frame = 1'b0;
            m_ext = 1'b0; m_rel = 1'b0;
            e_err = 1'b1;
        end
        if (has_edge) begin
            void'(q_s.pop_front());
            d = q_d.pop_front();
            if (!m_in_frame) begin
                if (d == 1'b0) begin
                    m_in_frame = 1'b1; m_nb = 0; m_last_s = n;
                end
            end else begin
                m_bits[m_nb] = d;
                m_nb++;
                m_last_s = n;
                if (m_nb == 10) begin
                    m_in_frame = 1'b0;
                    finish_frame(n);
                end
            end
        end
        if (p_at == n) begin
            p_at = -1;
            if (p_err) e_err = 1'b1;
            else begin
                e_kv = 1'b1; e_code = p_code; e_ext = p_ext; e_rel = p_rel;
            end
        end
        e_busy = m_in_frame;
    endfunction

    always @(posedge clk) begin
        bit rs;
        rs = reset;
        cyc++;
        #1;
        if (rs) begin
            model_reset();
            started = 1'b1;
        end else if (started) begin
            model_step(cyc);
        end
        if (started) begin
            chk("key_valid", 32'(key_valid), 32'(e_kv));
            chk("frame_err", 32'(frame_err), 32'(e_err));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("key_code", 32'(key_code), 32'(e_code));
            chk("key_ext", 32'(key_ext), 32'(e_ext));
            chk("key_release", 32'(key_release), 32'(e_rel));
            if (key_valid === 1'b1) kv_cnt++;
            if (frame_err === 1'b1) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int from, input int upto,
                             input int half, input int glitch_bit);
        for (int i = from; i <= upto; i++) begin
            ps2data = fr[i];
            tick(half);
            ps2clk = 1'b0;
            last_edge_s = cyc + 1 + LAT;
            q_s.push_back(last_edge_s);
            q_d.push_back(fr[i]);
            tick(half);
            ps2clk = 1'b1;
            if (i == glitch_bit) begin
                tick(20);
                ps2clk = 1'b0;
                tick(7);
                ps2clk = 1'b1;
            end
        end
        tick(half);
        ps2data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_bits(mkframe(b, bad_par, 1'b0), 0, 10, 40, -1);
        tick(60);
    endtask

    initial begin
        int kv0, e0, half, sel, upto, gb;
        longint s0;
        logic [7:0] b;
        logic [10:0] fr;

        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(5);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key_code", 32'(key_code), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_err", 32'(frame_err), 0);

        kv0 = kv_cnt;
        send_byte(8'h1C, 1'b0);
        chk("plain_code", 32'(key_code), 32'h1C);
        chk("plain_ext", 32'(key_ext), 0);
        chk("plain_rel", 32'(key_release), 0);
        chk("plain_count", 32'(kv_cnt - kv0), 1);
        chk("plain_no_err", 32'(err_cnt), 0);

        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("brk_code", 32'(key_code), 32'h1C);
        chk("brk_rel", 32'(key_release), 1);
        chk("brk_ext", 32'(key_ext), 0);
        kv0 = kv_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("extbrk_code", 32'(key_code), 32'h75);
        chk("extbrk_ext", 32'(key_ext), 1);
        chk("extbrk_rel", 32'(key_release), 1);
        chk("extbrk_count", 32'(kv_cnt - kv0), 1);
        send_byte(8'h1C, 1'b0);
        chk("after_ext", 32'(key_ext), 0);
        chk("after_rel", 32'(key_release), 0);

        send_byte(8'hF0, 1'b0);
        kv0 = kv_cnt;
        e0 = err_cnt;
        send_byte(8'h1C, 1'b1);
        chk("par_err_count", 32'(err_cnt - e0), 1);
        chk("par_no_key", 32'(kv_cnt - kv0), 0);
        send_byte(8'h29, 1'b0);
        chk("par_next_code", 32'(key_code), 32'h29);
        chk("par_next_rel", 32'(key_release), 0);

        e0 = err_cnt;
        send_bits(mkframe(8'h33, 1'b0, 1'b0), 0, 4, 40, -1);
        s0 = last_edge_s;
        chk("to_busy_mid", 32'(busy), 1);
        tick(int'(T) + 50);
        chk("to_err_count", 32'(err_cnt - e0), 1);
        chk("to_err_cycle", 32'(last_err_cyc - s0), 32'(T + 1));
        chk("to_busy_drop", 32'(busy), 0);
        send_byte(8'h1C, 1'b0);
        chk("to_next_code", 32'(key_code), 32'h1C);

        send_byte(8'h4D, 1'b0);
        kv0 = kv_cnt;
        e0 = err_cnt;
        ps2clk = 1'b0;
        tick(3);
        ps2clk = 1'b1;
        tick(30);
        chk("glitch_idle_busy", 32'(busy), 0);
        send_bits(mkframe(8'h1C, 1'b0, 1'b0), 0, 10, 40, 3);
        tick(60);
        chk("glitch_code", 32'(key_code), 32'h1C);
        chk("glitch_count", 32'(kv_cnt - kv0), 1);
        chk("glitch_no_err", 32'(err_cnt - e0), 0);

        fr = mkframe(8'h34, 1'b0, 1'b0);
        send_bits(fr, 0, 4, 40, -1);
        tick(20);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_valid", 32'(key_valid), 0);
        chk("mid_rst_code", 32'(key_code), 0);
        chk("mid_rst_ext", 32'(key_ext), 0);
        chk("mid_rst_rel", 32'(key_release), 0);
        chk("mid_rst_err", 32'(frame_err), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        send_bits(fr, 5, 10, 40, -1);
        tick(int'(T) + 50);
        send_byte(8'h5A, 1'b0);
        chk("mid_rst_next", 32'(key_code), 32'h5A);

        for (int r = 0; r < 26; r++) begin
            sel = int'($urandom_range(0, 15));
            if (sel < 3) b = 8'hE0;
            else if (sel < 5) b = 8'hF0;
            else if (sel == 5) b = specials[$urandom_range(0, 5)];
            else if (sel == 6) b = 8'hE1;
            else b = 8'($urandom);
            half = int'($urandom_range(20, 60));
            fr = mkframe(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
            gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            if ($urandom_range(0, 11) == 0) begin
                upto = int'($urandom_range(1, 9));
                send_bits(fr, 0, upto, half, -1);
                tick(int'(T) + 30);
            end else begin
                send_bits(fr, 0, 10, half, gb);
                tick(int'($urandom_range(30, 200)));
            end
        end

        tick(100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
